// File: rtl/f_bpred_npc_pkg.sv
// Shared definitions for the fetch-stage branch predictor: 2-bit counter
// encodings and the saturating counter update.
package f_bpred_npc_pkg;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t BP_SNT = 2'b00;
    localparam bp_ctr_t BP_WNT = 2'b01;
    localparam bp_ctr_t BP_WT  = 2'b10;
    localparam bp_ctr_t BP_ST  = 2'b11;

    function automatic bp_ctr_t ctr_next(input bp_ctr_t ctr, input logic taken);
        if (taken)
            return (ctr == BP_ST) ? BP_ST : bp_ctr_t'(ctr + 2'd1);
        else
            return (ctr == BP_SNT) ? BP_SNT : bp_ctr_t'(ctr - 2'd1);
    endfunction

endpackage

// File: rtl/f_bpred_npc_if.sv
// Fetch/execute bus of the next-PC generator: fetch lookup, E-stage resolve
// inputs and the predictor outputs.
interface f_bpred_npc_if #(parameter int CNT_W = 32);

    logic             f_en;
    logic [31:0]      f_pc;
    logic             f_bp_taken;
    logic [31:0]      f_bp_target;
    logic [31:0]      npc;
    logic             redirect;
    logic             e_valid;
    logic             e_is_br;
    logic [31:0]      e_pc;
    logic             e_taken;
    logic [31:0]      e_target;
    logic             e_pred_taken;
    logic [31:0]      e_pred_target;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;

    modport master (
        output f_en, f_pc, e_valid, e_is_br, e_pc, e_taken, e_target,
               e_pred_taken, e_pred_target,
        input  f_bp_taken, f_bp_target, npc, redirect, br_cnt, mis_cnt
    );

    modport slave (
        input  f_en, f_pc, e_valid, e_is_br, e_pc, e_taken, e_target,
               e_pred_taken, e_pred_target,
        output f_bp_taken, f_bp_target, npc, redirect, br_cnt, mis_cnt
    );

endinterface

// File: rtl/f_btb.sv
// Direct-mapped branch target buffer: combinational lookup port, synchronous
// update port. A same-index lookup and update sees the pre-update contents.
module f_btb
    import f_bpred_npc_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic             rd_taken,
    output logic [31:0]      rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic [31:0]      wr_target
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] valid_mem;
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [31:0]      tgt_mem [DEPTH];
    bp_ctr_t          ctr_mem [DEPTH];

    logic wr_hit;

    always_comb begin
        rd_hit    = valid_mem[rd_idx] && (tag_mem[rd_idx] == rd_tag);
        rd_taken  = rd_hit && ctr_mem[rd_idx][1];
        rd_target = rd_hit ? tgt_mem[rd_idx] : 32'h0;
        wr_hit    = valid_mem[wr_idx] && (tag_mem[wr_idx] == wr_tag);
    end

    // Hits train the counter; only taken misses allocate, starting weakly taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_mem <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem[i] <= '0;
                tgt_mem[i] <= '0;
                ctr_mem[i] <= BP_WNT;
            end
        end else if (wr_en) begin
            if (wr_hit) begin
                ctr_mem[wr_idx] <= ctr_next(ctr_mem[wr_idx], wr_taken);
                if (wr_taken)
                    tgt_mem[wr_idx] <= wr_target;
            end else if (wr_taken) begin
                valid_mem[wr_idx] <= 1'b1;
                tag_mem[wr_idx]   <= wr_tag;
                tgt_mem[wr_idx]   <= wr_target;
                ctr_mem[wr_idx]   <= BP_WT;
            end
        end
    end

endmodule

// File: rtl/f_bpred_npc.sv
// Fetch-stage next-PC generator: BTB prediction applied after the delay slot,
// E-stage mispredict redirect, and resolve/mispredict statistics.
module f_bpred_npc
    import f_bpred_npc_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8,
    parameter int CNT_W = 32
) (
    input logic          clk,
    input logic          reset,
    f_bpred_npc_if.slave bus
);

    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + TAG_W + 1;

    logic        res;
    logic        mis;
    logic [31:0] fix_pc;
    logic        pend_v;
    logic [31:0] pend_pc;
    logic        hold_v;
    logic [31:0] hold_pc;
    logic        btb_hit;

    f_btb #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (bus.f_pc[IDX_W+1:2]),
        .rd_tag    (bus.f_pc[TAG_HI:TAG_LO]),
        .rd_hit    (btb_hit),
        .rd_taken  (bus.f_bp_taken),
        .rd_target (bus.f_bp_target),
        .wr_en     (res),
        .wr_idx    (bus.e_pc[IDX_W+1:2]),
        .wr_tag    (bus.e_pc[TAG_HI:TAG_LO]),
        .wr_taken  (bus.e_taken),
        .wr_target (bus.e_target)
    );

    always_comb begin
        res = bus.e_valid && bus.e_is_br;
        mis = res && ((bus.e_taken != bus.e_pred_taken) ||
                      (bus.e_taken && (bus.e_target != bus.e_pred_target)));
        fix_pc = bus.e_taken ? bus.e_target : bus.e_pc + 32'd8;
        bus.redirect = mis || hold_v;
        if (mis)
            bus.npc = fix_pc;
        else if (hold_v)
            bus.npc = hold_pc;
        else if (pend_v)
            bus.npc = pend_pc;
        else
            bus.npc = bus.f_pc + 32'd4;
    end

    // The prediction of a fetched branch waits here while its delay slot is fetched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_v  <= 1'b0;
            pend_pc <= 32'h0;
        end else if (bus.redirect) begin
            pend_v <= 1'b0;
        end else if (bus.f_en) begin
            pend_v  <= bus.f_bp_taken;
            pend_pc <= bus.f_bp_target;
        end
    end

    // A mispredict during a stall is remembered until fetch can advance to it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_v  <= 1'b0;
            hold_pc <= 32'h0;
        end else if (bus.f_en) begin
            hold_v <= 1'b0;
        end else if (mis) begin
            hold_v  <= 1'b1;
            hold_pc <= fix_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.br_cnt  <= '0;
            bus.mis_cnt <= '0;
        end else begin
            if (res && (bus.br_cnt != '1))
                bus.br_cnt <= bus.br_cnt + CNT_W'(1);
            if (mis && (bus.mis_cnt != '1))
                bus.mis_cnt <= bus.mis_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_f_bpred_npc.sv
// Directed testbench for f_bpred_npc: BTB training, delay-slot prediction,
// stall/hold redirect behaviour, aliasing and asynchronous reset.
module tb_f_bpred_npc;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    f_bpred_npc_if #(.CNT_W(32)) bus ();

    f_bpred_npc #(.IDX_W(4), .TAG_W(8), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic e_resolve(input logic valid, input logic [31:0] pc, input logic taken,
                             input logic [31:0] target, input logic pred_taken,
                             input logic [31:0] pred_target);
        bus.e_valid       = valid;
        bus.e_is_br       = valid;
        bus.e_pc          = pc;
        bus.e_taken       = taken;
        bus.e_target      = target;
        bus.e_pred_taken  = pred_taken;
        bus.e_pred_target = pred_target;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.f_en    = 1'b1;
        bus.f_pc    = 32'h3000;
        e_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("rst_bp_taken", 32'(bus.f_bp_taken), 32'd0);
        check("rst_npc", bus.npc, 32'h3004);
        check("rst_redirect", 32'(bus.redirect), 32'd0);
        check("rst_br_cnt", bus.br_cnt, 32'd0);
        check("rst_mis_cnt", bus.mis_cnt, 32'd0);
        reset = 1'b0;

        // Unpredicted taken branch at 0x3010 allocates the BTB entry.
        bus.f_pc = 32'h3008;
        e_resolve(1'b1, 32'h3010, 1'b1, 32'h3040, 1'b0, 32'h0);
        #1;
        check("mis1_redirect", 32'(bus.redirect), 32'd1);
        check("mis1_npc", bus.npc, 32'h3040);
        tick();
        e_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.f_pc = 32'h3010;
        #1;
        check("mis1_cnt", bus.mis_cnt, 32'd1);
        check("br1_cnt", bus.br_cnt, 32'd1);
        check("hit_taken", 32'(bus.f_bp_taken), 32'd1);
        check("hit_target", bus.f_bp_target, 32'h3040);
        check("pre_pend_npc", bus.npc, 32'h3014);
        tick();
        bus.f_pc = 32'h3014;
        #1;
        check("delay_slot_npc", bus.npc, 32'h3040);
        check("delay_slot_redirect", 32'(bus.redirect), 32'd0);
        tick();

        // Counter training on entry 0x3010 while fetch is stalled.
        bus.f_en = 1'b0;
        bus.f_pc = 32'h3010;
        e_resolve(1'b1, 32'h3010, 1'b1, 32'h3040, 1'b1, 32'h3040);
        #1;
        check("t1_redirect", 32'(bus.redirect), 32'd0);
        tick();
        #1;
        check("t2_br_cnt", bus.br_cnt, 32'd2);
        tick();
        e_resolve(1'b1, 32'h3010, 1'b0, 32'h3040, 1'b0, 32'h3040);
        #1;
        check("nt1_redirect", 32'(bus.redirect), 32'd0);
        check("nt1_mis_cnt", bus.mis_cnt, 32'd1);
        tick();
        e_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("ctr10_taken", 32'(bus.f_bp_taken), 32'd1);
        check("nt1_br_cnt", bus.br_cnt, 32'd4);
        e_resolve(1'b1, 32'h3010, 1'b0, 32'h3040, 1'b1, 32'h3040);
        #1;
        check("nt2_redirect", 32'(bus.redirect), 32'd1);
        check("nt2_npc", bus.npc, 32'h3018);
        tick();
        e_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.f_en = 1'b1;
        #1;
        check("ctr01_taken", 32'(bus.f_bp_taken), 32'd0);
        check("ctr01_target", bus.f_bp_target, 32'h3040);
        check("nt2_mis_cnt", bus.mis_cnt, 32'd2);
        check("hold_redirect", 32'(bus.redirect), 32'd1);
        check("hold_npc", bus.npc, 32'h3018);
        tick();
        #1;
        check("ctr01_npc", bus.npc, 32'h3014);
        check("hold_clear_redirect", 32'(bus.redirect), 32'd0);
        tick();

        // Taken again with a not-taken prediction: mispredict.
        bus.f_pc = 32'h3014;
        e_resolve(1'b1, 32'h3010, 1'b1, 32'h3040, 1'b0, 32'h0);
        #1;
        check("t3_npc", bus.npc, 32'h3040);
        tick();
        e_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.f_pc = 32'h3010;
        #1;
        check("t3_mis_cnt", bus.mis_cnt, 32'd3);
        check("t3_br_cnt", bus.br_cnt, 32'd6);
        check("t3_bp_taken", 32'(bus.f_bp_taken), 32'd1);
        tick();

        // Stall with a pending prediction, then a mispredict inside the stall.
        bus.f_pc = 32'h3014;
        bus.f_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_pend_npc", bus.npc, 32'h3040);
            tick();
        end
        e_resolve(1'b1, 32'h30f0, 1'b1, 32'h3100, 1'b0, 32'h0);
        #1;
        check("stall_mis_npc", bus.npc, 32'h3100);
        tick();
        e_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("stall_hold_redirect", 32'(bus.redirect), 32'd1);
        check("stall_hold_npc", bus.npc, 32'h3100);
        tick();
        bus.f_en = 1'b1;
        #1;
        check("stall_release_redirect", 32'(bus.redirect), 32'd1);
        tick();
        bus.f_pc = 32'h3100;
        #1;
        check("post_stall_redirect", 32'(bus.redirect), 32'd0);
        check("post_stall_npc", bus.npc, 32'h3104);
        check("stall_mis_cnt", bus.mis_cnt, 32'd4);

        // Mispredict in the same cycle as a pending prediction.
        bus.f_pc = 32'h3010;
        tick();
        bus.f_pc = 32'h3014;
        e_resolve(1'b1, 32'h30f0, 1'b1, 32'h3100, 1'b0, 32'h0);
        #1;
        check("mis_pend_npc", bus.npc, 32'h3100);
        tick();
        e_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.f_pc = 32'h3100;
        #1;
        check("mis_pend_cleared", bus.npc, 32'h3104);

        // Same index as 0x3010, different tag: no hit.
        bus.f_pc = 32'h3410;
        #1;
        check("alias_taken", 32'(bus.f_bp_taken), 32'd0);
        check("alias_target", bus.f_bp_target, 32'h0);
        check("alias_npc", bus.npc, 32'h3414);
        tick();

        // Asynchronous reset while a redirect is being held.
        bus.f_en = 1'b0;
        e_resolve(1'b1, 32'h3010, 1'b0, 32'h3040, 1'b1, 32'h3040);
        tick();
        e_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.f_pc = 32'h3200;
        #1;
        check("pre_rst_hold_npc", bus.npc, 32'h3018);
        reset = 1'b1;
        #1;
        check("async_rst_redirect", 32'(bus.redirect), 32'd0);
        check("async_rst_npc", bus.npc, 32'h3204);
        check("async_rst_mis_cnt", bus.mis_cnt, 32'd0);
        bus.f_pc = 32'h3010;
        #1;
        check("async_rst_btb", 32'(bus.f_bp_taken), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
